ewma_decision_mc: RTL and testbench

- Multi-channel successor of the single-channel EWMA jamming decision block.
- Compares signed EWMA RSSI samples against runtime-programmable upper and lower control limits (UCL/LCL).
- Per-channel persistence FSM applies set/clear hysteresis, so isolated outliers do not raise alerts.
- Sits after the EWMA filter; drives per-channel alerts, an OR-reduced alert, transition events and saturating onset counters to the monitoring/CSR logic.

---
 rtl/ewma_decision_pkg.sv | 33 +++
 rtl/ewma_decision_mc_if.sv | 28 ++
 rtl/ewma_decision_chan.sv | 125 ++++++++++++
 rtl/ewma_decision_mc.sv | 104 ++++++++++
 tb/tb_ewma_decision_mc.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ewma_decision_pkg.sv
// Shared types and helpers for the multi-channel EWMA decision block.
// State encodings, width helpers and the signed band compare.
package ewma_decision_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IN_BAND = 2'd0;
    localparam state_t PENDING = 2'd1;
    localparam state_t ALERT   = 2'd2;
    localparam state_t RECOVER = 2'd3;

    // Compare width; samples of DATA_W <= CMP_W are sign-extended to it.
    localparam int CMP_W = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pc_w(input int s, input int c);
        int m;
        m = (s > c) ? s : c;
        return $clog2(m + 1);
    endfunction

    function automatic logic out_of_band(
        input logic signed [CMP_W-1:0] s,
        input logic signed [CMP_W-1:0] u,
        input logic signed [CMP_W-1:0] l
    );
        return (s > u) || (s < l);
    endfunction

endpackage

// File: rtl/ewma_decision_mc_if.sv
// Sample bus from the EWMA filter into the decision block.
// The filter side is master, the decision block is slave.
interface ewma_decision_mc_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
);
    logic                     sample_valid_i;
    logic [CH_W-1:0]          sample_ch_i;
    logic signed [DATA_W-1:0] sample_i;
    logic signed [DATA_W-1:0] ucl_i;
    logic signed [DATA_W-1:0] lcl_i;

    modport master (
        output sample_valid_i,
        output sample_ch_i,
        output sample_i,
        output ucl_i,
        output lcl_i
    );

    modport slave (
        input sample_valid_i,
        input sample_ch_i,
        input sample_i,
        input ucl_i,
        input lcl_i
    );
endinterface

// File: rtl/ewma_decision_chan.sv
// One channel: persistence FSM with set/clear hysteresis
// plus a saturating onset counter.
module ewma_decision_chan
    import ewma_decision_pkg::*;
#(
    parameter int SET_CNT = 3,
    parameter int CLR_CNT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             acc_i,
    input  logic             out_i,
    input  logic             cnt_clr_i,
    output logic             alert_o,
    output logic             alert_nxt_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PC_W = pc_w(SET_CNT, CLR_CNT);
    localparam logic [PC_W-1:0] SET_V = PC_W'(SET_CNT);
    localparam logic [PC_W-1:0] CLR_V = PC_W'(CLR_CNT);
    localparam logic [PC_W-1:0] ONE_V = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign pc_inc = pc_q + ONE_V;

    // Next-state and strobes; only an accepted sample moves the FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rise_o  = 1'b0;
        fall_o  = 1'b0;
        if (acc_i) begin
            unique case (state_q)
                IN_BAND: begin
                    if (out_i) begin
                        if (SET_CNT == 1) begin
                            state_d = ALERT;
                            rise_o  = 1'b1;
                        end else begin
                            state_d = PENDING;
                            pc_d    = ONE_V;
                        end
                    end
                end
                PENDING: begin
                    if (out_i) begin
                        if (pc_inc == SET_V) begin
                            state_d = ALERT;
                            pc_d    = '0;
                            rise_o  = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end else begin
                        state_d = IN_BAND;
                        pc_d    = '0;
                    end
                end
                ALERT: begin
                    if (!out_i) begin
                        if (CLR_CNT == 1) begin
                            state_d = IN_BAND;
                            fall_o  = 1'b1;
                        end else begin
                            state_d = RECOVER;
                            pc_d    = ONE_V;
                        end
                    end
                end
                RECOVER: begin
                    if (!out_i) begin
                        if (pc_inc == CLR_V) begin
                            state_d = IN_BAND;
                            pc_d    = '0;
                            fall_o  = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end else begin
                        state_d = ALERT;
                        pc_d    = '0;
                    end
                end
                default: begin
                    state_d = IN_BAND;
                    pc_d    = '0;
                end
            endcase
        end
    end

    // Onset counter: clear first, then count a rise, saturating.
    always_comb begin
        cnt_d = cnt_clr_i ? '0 : cnt_q;
        if (rise_o && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // State, persistence and counter registers.
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state_q <= IN_BAND;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alert_o     = (state_q == ALERT) || (state_q == RECOVER);
    assign alert_nxt_o = (state_d == ALERT) || (state_d == RECOVER);
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/ewma_decision_mc.sv
// Multi-channel EWMA jamming decision: channel decode, per-channel
// FSMs, event muxing, OR-reduced alert and counter bus packing.
module ewma_decision_mc
    import ewma_decision_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 4,
    parameter int SET_CNT = 3,
    parameter int CLR_CNT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk_h,
    input  logic                    rst_h,
    ewma_decision_mc_if.slave       smp,
    input  logic [NUM_CH-1:0]       cnt_clr_i,
    output logic [NUM_CH-1:0]       alert_o,
    output logic                    alert_any_o,
    output logic                    event_valid_o,
    output logic [idx_w(NUM_CH)-1:0] event_ch_o,
    output logic                    event_rise_o,
    output logic [NUM_CH*CNT_W-1:0] alert_cnt_o
);

    localparam int CH_W = idx_w(NUM_CH);

    logic                    acc;
    logic                    oob;
    logic signed [CMP_W-1:0] s_ext, u_ext, l_ext;
    logic [NUM_CH-1:0]       ch_acc;
    logic [NUM_CH-1:0]       alert_nxt;
    logic [NUM_CH-1:0]       rise;
    logic [NUM_CH-1:0]       fall;

    logic            ev_valid_q, ev_valid_d;
    logic [CH_W-1:0] ev_ch_q, ev_ch_d;
    logic            ev_rise_q, ev_rise_d;
    logic            any_q, any_d;

    // Range-check the channel and classify the sample against the band.
    always_comb begin
        s_ext = CMP_W'(smp.sample_i);
        u_ext = CMP_W'(smp.ucl_i);
        l_ext = CMP_W'(smp.lcl_i);
        oob   = out_of_band(s_ext, u_ext, l_ext);
        acc   = smp.sample_valid_i && (32'(smp.sample_ch_i) < NUM_CH);
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_acc[k] = acc && (smp.sample_ch_i == CH_W'(k));

        ewma_decision_chan #(
            .SET_CNT (SET_CNT),
            .CLR_CNT (CLR_CNT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk_h       (clk_h),
            .rst_h       (rst_h),
            .acc_i       (ch_acc[k]),
            .out_i       (oob),
            .cnt_clr_i   (cnt_clr_i[k]),
            .alert_o     (alert_o[k]),
            .alert_nxt_o (alert_nxt[k]),
            .rise_o      (rise[k]),
            .fall_o      (fall[k]),
            .cnt_o       (alert_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    // Select the single transitioning channel; hold fields otherwise.
    always_comb begin
        ev_valid_d = 1'b0;
        ev_ch_d    = ev_ch_q;
        ev_rise_d  = ev_rise_q;
        any_d      = |alert_nxt;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rise[k] || fall[k]) begin
                ev_valid_d = 1'b1;
                ev_ch_d    = CH_W'(k);
                ev_rise_d  = rise[k];
            end
        end
    end

    // Event and summary-alert registers.
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            ev_valid_q <= 1'b0;
            ev_ch_q    <= '0;
            ev_rise_q  <= 1'b0;
            any_q      <= 1'b0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_ch_q    <= ev_ch_d;
            ev_rise_q  <= ev_rise_d;
            any_q      <= any_d;
        end
    end

    assign event_valid_o = ev_valid_q;
    assign event_ch_o    = ev_ch_q;
    assign event_rise_o  = ev_rise_q;
    assign alert_any_o   = any_q;

endmodule

// File: tb/tb_ewma_decision_mc.sv
// Directed self-checking bench for ewma_decision_mc.
// Five channels so that out-of-range indices 5..7 are expressible.
module tb_ewma_decision_mc;

    localparam int NCH  = 5;
    localparam int CW   = 2;
    localparam int CHW  = 3;

    logic clk_h = 1'b0;
    logic rst_h = 1'b1;
    logic [NCH-1:0]     cnt_clr_i = '0;
    logic [NCH-1:0]     alert_o;
    logic               alert_any_o;
    logic               event_valid_o;
    logic [CHW-1:0]     event_ch_o;
    logic               event_rise_o;
    logic [NCH*CW-1:0]  alert_cnt_o;

    logic signed [31:0] ucl = -32'sd65;
    logic signed [31:0] lcl = -32'sd106;

    int checks = 0;
    int failures = 0;

    ewma_decision_mc_if #(.DATA_W(32), .CH_W(CHW)) smp ();

    ewma_decision_mc #(
        .DATA_W  (32),
        .NUM_CH  (NCH),
        .SET_CNT (3),
        .CLR_CNT (4),
        .CNT_W   (CW)
    ) dut (
        .clk_h         (clk_h),
        .rst_h         (rst_h),
        .smp           (smp),
        .cnt_clr_i     (cnt_clr_i),
        .alert_o       (alert_o),
        .alert_any_o   (alert_any_o),
        .event_valid_o (event_valid_o),
        .event_ch_o    (event_ch_o),
        .event_rise_o  (event_rise_o),
        .alert_cnt_o   (alert_cnt_o)
    );

    always #5 clk_h = ~clk_h;

    function automatic logic [CW-1:0] cnt_of(input int k);
        return alert_cnt_o[k*CW +: CW];
    endfunction

    task automatic send(input int ch, input logic signed [31:0] v);
        smp.sample_valid_i = 1'b1;
        smp.sample_ch_i    = CHW'(ch);
        smp.sample_i       = v;
        smp.ucl_i          = ucl;
        smp.lcl_i          = lcl;
        @(posedge clk_h);
        #1;
        smp.sample_valid_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk_h);
        #1;
    endtask

    task automatic do_reset();
        rst_h = 1'b1;
        idle();
        idle();
        rst_h = 1'b0;
        ucl = -32'sd65;
        lcl = -32'sd106;
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        idle();
        checks++;
        if (alert_o !== 5'b0) begin
            failures++;
            $display("FAIL reset_alert got=%b exp=0", alert_o);
        end
        checks++;
        if (alert_any_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_any got=%b exp=0", alert_any_o);
        end
        checks++;
        if ({event_valid_o, event_rise_o, event_ch_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_event got=%b%b%0d exp=0",
                     event_valid_o, event_rise_o, event_ch_o);
        end
        checks++;
        if (alert_cnt_o !== '0) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=0", alert_cnt_o);
        end
    endtask

    task automatic test_persistence();
        send(1, -60);
        send(1, -60);
        send(1, -70);
        checks++;
        if (alert_o !== 5'b0) begin
            failures++;
            $display("FAIL persist_glitch got=%b exp=0", alert_o);
        end
        send(1, -60);
        send(1, -60);
        checks++;
        if (alert_o !== 5'b0) begin
            failures++;
            $display("FAIL persist_restart got=%b exp=0", alert_o);
        end
        send(1, -60);
        checks++;
        if (alert_o !== 5'b00010 || alert_any_o !== 1'b1) begin
            failures++;
            $display("FAIL persist_rise got=%b any=%b exp=00010 any=1",
                     alert_o, alert_any_o);
        end
        checks++;
        if (event_valid_o !== 1'b1 || event_rise_o !== 1'b1 ||
            event_ch_o !== 3'd1) begin
            failures++;
            $display("FAIL persist_event got=v%b r%b ch%0d exp=v1 r1 ch1",
                     event_valid_o, event_rise_o, event_ch_o);
        end
        checks++;
        if (cnt_of(1) !== 2'd1) begin
            failures++;
            $display("FAIL persist_cnt got=%0d exp=1", cnt_of(1));
        end
        idle();
        checks++;
        if (event_valid_o !== 1'b0 || event_ch_o !== 3'd1 ||
            event_rise_o !== 1'b1) begin
            failures++;
            $display("FAIL persist_hold got=v%b r%b ch%0d exp=v0 r1 ch1",
                     event_valid_o, event_rise_o, event_ch_o);
        end
    endtask

    task automatic test_recovery();
        send(1, -80);
        send(1, -80);
        send(1, -80);
        send(1, -110);
        checks++;
        if (alert_o !== 5'b00010 || event_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL recov_hold got=%b ev=%b exp=00010 ev=0",
                     alert_o, event_valid_o);
        end
        send(1, -80);
        send(1, -80);
        send(1, -80);
        checks++;
        if (alert_o !== 5'b00010) begin
            failures++;
            $display("FAIL recov_early got=%b exp=00010", alert_o);
        end
        send(1, -80);
        checks++;
        if (alert_o !== 5'b0 || alert_any_o !== 1'b0) begin
            failures++;
            $display("FAIL recov_drop got=%b any=%b exp=0 any=0",
                     alert_o, alert_any_o);
        end
        checks++;
        if (event_valid_o !== 1'b1 || event_rise_o !== 1'b0 ||
            event_ch_o !== 3'd1) begin
            failures++;
            $display("FAIL recov_event got=v%b r%b ch%0d exp=v1 r0 ch1",
                     event_valid_o, event_rise_o, event_ch_o);
        end
    endtask

    task automatic test_boundary();
        send(0, -107);
        send(0, -65);
        send(0, -107);
        send(0, -106);
        send(0, 32'sh7FFF_FFFF);
        send(0, 32'sh7FFF_FFFF);
        checks++;
        if (alert_o !== 5'b0) begin
            failures++;
            $display("FAIL bound_equal got=%b exp=0", alert_o);
        end
        send(0, 32'sh7FFF_FFFF);
        checks++;
        if (alert_o !== 5'b00001 || event_ch_o !== 3'd0 ||
            event_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL bound_max got=%b ch%0d v%b exp=00001 ch0 v1",
                     alert_o, event_ch_o, event_valid_o);
        end
    endtask

    task automatic test_counter();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(2, -60);
            send(2, -60);
            send(2, -60);
            checks++;
            if (cnt_of(2) !== CW'((i > 3) ? 3 : i)) begin
                failures++;
                $display("FAIL cnt_onset%0d got=%0d exp=%0d",
                         i, cnt_of(2), (i > 3) ? 3 : i);
            end
            for (int j = 0; j < 4; j++) send(2, -80);
        end
        send(2, -60);
        send(2, -60);
        cnt_clr_i[2] = 1'b1;
        send(2, -60);
        cnt_clr_i[2] = 1'b0;
        checks++;
        if (cnt_of(2) !== 2'd1) begin
            failures++;
            $display("FAIL cnt_clr_rise got=%0d exp=1", cnt_of(2));
        end
        cnt_clr_i[2] = 1'b1;
        idle();
        cnt_clr_i[2] = 1'b0;
        checks++;
        if (cnt_of(2) !== 2'd0 || alert_o !== 5'b00100) begin
            failures++;
            $display("FAIL cnt_clr_only got=%0d alert=%b exp=0 alert=00100",
                     cnt_of(2), alert_o);
        end
    endtask

    task automatic test_reset_mid();
        send(2, -80);
        rst_h = 1'b1;
        send(2, -60);
        rst_h = 1'b0;
        checks++;
        if (alert_o !== 5'b0 || alert_any_o !== 1'b0 ||
            event_valid_o !== 1'b0 || alert_cnt_o !== '0) begin
            failures++;
            $display("FAIL rstmid_out got=%b any=%b v=%b cnt=%h exp=all0",
                     alert_o, alert_any_o, event_valid_o, alert_cnt_o);
        end
        send(2, -60);
        send(2, -60);
        checks++;
        if (alert_o !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_fsm got=%b exp=0", alert_o);
        end
    endtask

    task automatic test_interleave();
        do_reset();
        send(0, -60);
        send(3, -80);
        send(0, -60);
        send(3, -60);
        send(0, -60);
        checks++;
        if (alert_o !== 5'b00001 || event_ch_o !== 3'd0) begin
            failures++;
            $display("FAIL inter_ch0 got=%b ch%0d exp=00001 ch0",
                     alert_o, event_ch_o);
        end
        send(3, -60);
        checks++;
        if (alert_o !== 5'b00001) begin
            failures++;
            $display("FAIL inter_ch3_early got=%b exp=00001", alert_o);
        end
        send(3, -60);
        checks++;
        if (alert_o !== 5'b01001 || event_ch_o !== 3'd3 ||
            cnt_of(3) !== 2'd1 || cnt_of(0) !== 2'd1) begin
            failures++;
            $display("FAIL inter_ch3 got=%b ch%0d c3=%0d c0=%0d exp=01001 ch3 1 1",
                     alert_o, event_ch_o, cnt_of(3), cnt_of(0));
        end
    endtask

    task automatic test_bad_channel();
        do_reset();
        send(1, -60);
        send(1, -60);
        send(5, -60);
        send(7, -60);
        checks++;
        if (alert_o !== 5'b0 || event_valid_o !== 1'b0 ||
            alert_cnt_o !== '0) begin
            failures++;
            $display("FAIL badch_ignored got=%b v=%b cnt=%h exp=0",
                     alert_o, event_valid_o, alert_cnt_o);
        end
        send(1, -60);
        checks++;
        if (alert_o !== 5'b00010) begin
            failures++;
            $display("FAIL badch_ch1 got=%b exp=00010", alert_o);
        end
    endtask

    task automatic test_inverted();
        do_reset();
        ucl = -32'sd70;
        lcl = -32'sd60;
        send(4, -65);
        send(4, -65);
        checks++;
        if (alert_o !== 5'b0) begin
            failures++;
            $display("FAIL inv_early got=%b exp=0", alert_o);
        end
        send(4, -65);
        checks++;
        if (alert_o !== 5'b10000 || event_ch_o !== 3'd4 ||
            event_rise_o !== 1'b1) begin
            failures++;
            $display("FAIL inv_rise got=%b ch%0d r%b exp=10000 ch4 r1",
                     alert_o, event_ch_o, event_rise_o);
        end
    endtask

    initial begin
        smp.sample_valid_i = 1'b0;
        smp.sample_ch_i    = '0;
        smp.sample_i       = '0;
        smp.ucl_i          = '0;
        smp.lcl_i          = '0;
        @(posedge clk_h);
        #1;
        test_reset();
        test_persistence();
        test_recovery();
        test_boundary();
        test_counter();
        test_reset_mid();
        test_interleave();
        test_bad_channel();
        test_inverted();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
